// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
// Contents: FSM state encoding, maximum supported operand width.
package serial_add_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder.sv
// 1-bit full-adder cell shared by the serial adder datapath.
// Ports: A, B, C - addend bits and carry-in; sum, carry - combinational outputs.
module adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic sum,
  output logic carry
);

  assign sum   = A ^ B ^ C;
  assign carry = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: computes {cout,sum} = op_a + op_b + cin one bit
// per cycle, LSB first, through a single shared full-adder cell.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   in_valid/in_ready      - operand handshake (ready only while idle)
//   op_a, op_b, cin        - operands, sampled on the input handshake
//   out_valid/out_ready    - result handshake, result held until accepted
//   sum, cout              - result and final carry-out
//   ovf                    - signed overflow, present only with SERIAL_ADD_OVF_EN
// Optional feature macro: SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_add_ctrl: WIDTH must be in 1..%0d", MAX_WIDTH);
  end

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             cell_sum, cell_carry;
  logic             accept, step, last;

  // Single shared full-adder cell fed from the shift-register LSBs.
  adder u_adder (
    .A     (a_sr[0]),
    .B     (b_sr[0]),
    .C     (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign sum_nxt = (sum_sr >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept) begin
        a_sr    <= op_a;
        b_sr    <= op_b;
        carry_q <= cin;
        cnt     <= '0;
      end else if (step) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        sum_sr  <= sum_nxt;
        carry_q <= cell_carry;
        cnt     <= cnt + CNT_W'(1);
        if (last) begin
          sum  <= sum_nxt;
          cout <= cell_carry;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB during the last bit.
          ovf  <= carry_q ^ cell_carry;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: three instances (WIDTH 8, 13, 1)
// share one stimulus bus; cur_w selects which instance is driven and observed.
// Define SERIAL_ADD_OVF_EN to also check the ovf output.
module tb_serial_add_ctrl;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
    int          w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] op_a, op_b;
  logic        in_valid, cin;
  int unsigned cur_w;
  int          ordy_mode;
  logic        rnd_bit = 1'b1;
  logic        out_ready;

  assign out_ready = (ordy_mode == 1) || (ordy_mode == 2 && rnd_bit);
  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  logic iv8, ir8, ov8, or8, co8, f8;
  logic iv13, ir13, ov13, or13, co13, f13;
  logic iv1, ir1, ov1, or1, co1, f1;
  logic [7:0]  s8;
  logic [12:0] s13;
  logic [0:0]  s1;

  assign iv8  = in_valid && (cur_w == 8);
  assign iv13 = in_valid && (cur_w == 13);
  assign iv1  = in_valid && (cur_w == 1);
  assign or8  = out_ready && (cur_w == 8);
  assign or13 = out_ready && (cur_w == 13);
  assign or1  = out_ready && (cur_w == 1);

`ifndef SERIAL_ADD_OVF_EN
  assign f8  = 1'b0;
  assign f13 = 1'b0;
  assign f1  = 1'b0;
`endif

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .op_a(op_a[7:0]), .op_b(op_b[7:0]), .cin(cin),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(f8)
`endif
  );

  serial_add_ctrl #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv13), .in_ready(ir13),
    .op_a(op_a[12:0]), .op_b(op_b[12:0]), .cin(cin),
    .out_valid(ov13), .out_ready(or13), .sum(s13), .cout(co13)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(f13)
`endif
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .op_a(op_a[0:0]), .op_b(op_b[0:0]), .cin(cin),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(f1)
`endif
  );

  // Observed view of the selected instance.
  logic        obs_ir, obs_ov, obs_co, obs_f;
  logic [63:0] obs_s;
  always_comb begin
    obs_ir = ir8;
    obs_ov = ov8;
    obs_co = co8;
    obs_f  = f8;
    obs_s  = 64'(s8);
    if (cur_w == 13) begin
      obs_ir = ir13;
      obs_ov = ov13;
      obs_co = co13;
      obs_f  = f13;
      obs_s  = 64'(s13);
    end else if (cur_w == 1) begin
      obs_ir = ir1;
      obs_ov = ov1;
      obs_co = co1;
      obs_f  = f1;
      obs_s  = 64'(s1);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mask_w(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference model: plain wide addition, signed overflow from the carry into the MSB.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input int w);
    exp_t        e;
    logic [64:0] full, low;
    full      = {1'b0, a & mask_w(w)} + {1'b0, b & mask_w(w)} + 65'(c);
    low       = {1'b0, a & mask_w(w - 1)} + {1'b0, b & mask_w(w - 1)} + 65'(c);
    e.sum     = full[63:0] & mask_w(w);
    e.cout    = full[w];
    e.ovf     = low[w - 1] ^ full[w];
    e.acc_cyc = 0;
    e.w       = w;
    return e;
  endfunction

  // Scoreboard: push on input handshake, pop on output handshake.
  exp_t sb[$];
  exp_t mon_e;
  int   last_acc = 0;
  int   last_ohs = 0;
  logic ov_prev  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && obs_ir) begin
        mon_e         = model(op_a, op_b, cin, int'(cur_w));
        mon_e.acc_cyc = cyc;
        sb.push_back(mon_e);
        last_acc = cyc;
      end
      if (obs_ov && !ov_prev) begin
        check("result_pending", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0)
          check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].w + 1));
      end
      if (obs_ov && out_ready) begin
        last_ohs = cyc;
        check("result_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("sum", obs_s, mon_e.sum);
          check("cout", 64'(obs_co), 64'(mon_e.cout));
`ifdef SERIAL_ADD_OVF_EN
          check("ovf", 64'(obs_f), 64'(mon_e.ovf));
`endif
        end
      end
      ov_prev = obs_ov;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!obs_ir && n < 200);
    check(tag, 64'(obs_ir), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c,
                      input string tag);
    op_a     = a;
    op_b     = b;
    cin      = c;
    in_valid = 1'b1;
    wait_accept(tag);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!obs_ov && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(obs_ov), 64'(1));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(sb.size()), 64'(0));
    tick();
  endtask

  task automatic random_run(input int unsigned w, input int count);
    cur_w     = w;
    ordy_mode = 2;
    for (int i = 0; i < count; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), "acc_rand");
    drain("drain_rand");
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    cur_w     = 8;
    ordy_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(obs_ir), 64'(1));
    check("rst_out_valid", 64'(obs_ov), 64'(0));
    check("rst_sum", obs_s, 64'h0);
    check("rst_cout", 64'(obs_co), 64'(0));
    rst_n = 1'b1;
    tick();

    // Directed vectors with the consumer always ready.
    ordy_mode = 1;
    send(64'h5A, 64'h33, 1'b0, "acc_5a33");
    send(64'hFF, 64'h01, 1'b1, "acc_ff01");
    drain("drain_dir");

    // Consumer stall with a pending producer request.
    ordy_mode = 0;
    send(64'hC3, 64'h7E, 1'b1, "acc_stall1");
    wait_valid("stall_valid");
    tick();
    op_a     = 64'h11;
    op_b     = 64'h22;
    cin      = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_sum", obs_s, 64'h42);
      check("stall_cout", 64'(obs_co), 64'(1));
      check("stall_in_ready", 64'(obs_ir), 64'(0));
      check("stall_out_valid", 64'(obs_ov), 64'(1));
      tick();
    end
    ordy_mode = 1;
    wait_accept("acc_stall2");
    check("turnaround", 64'(last_acc - last_ohs), 64'(1));
    drain("drain_stall");

    // Reset during the third RUN cycle aborts the operation.
    send(64'hA5, 64'h96, 1'b0, "acc_rst");
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(obs_ir), 64'(1));
    check("abort_out_valid", 64'(obs_ov), 64'(0));
    check("abort_sum", obs_s, 64'h0);
    check("abort_cout", 64'(obs_co), 64'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      logic saw = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (obs_ov) saw = 1'b1;
      end
      check("abort_no_valid", 64'(saw), 64'(0));
    end
    tick();
    send(64'h80, 64'h80, 1'b0, "acc_post_rst");
    drain("drain_post_rst");

    // WIDTH=1 corner.
    cur_w = 1;
    send(64'h1, 64'h1, 1'b1, "acc_w1");
    drain("drain_w1");

    // Random back-to-back traffic with random consumer stalls.
    random_run(8, 1000);
    random_run(13, 1000);
    random_run(1, 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
